// File: rtl/keypad_scan.sv
// keypad_scan: row-scanning driver for a 4x4 active-low matrix keypad.
// Drives one row low at a time, samples the synchronized columns at the end
// of each row dwell, collapses each 4-row frame into NONE / ONE(code) / MULTI,
// and debounces whole frames into a single accepted key.
//
// Ports:
//   clk       board clock, rising-edge active
//   rst       synchronous active-high reset
//   col_n     keypad column lines, active-low, asynchronous to clk
//   row_n     keypad row drive, one-hot active-low
//   key_code  last accepted key, {row[1:0], col[1:0]}
//   key_valid one-cycle pulse when a new press is accepted
//   key_down  high while the accepted key is held
module keypad_scan #(
    parameter int SCAN_DIV = 131072,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;
    typedef enum logic [1:0] {FR_NONE, FR_ONE, FR_MULTI} frame_t;

    logic [DW-1:0] div;
    logic [1:0]    row_idx;
    logic          terminal;
    logic          frame_end;
    logic [3:0]    col_meta;
    logic [3:0]    col_s;
    logic [3:0]    act;
    logic          row_one;
    logic          row_multi;
    logic [1:0]    col_idx;
    logic [1:0]    acc_hits;
    logic [3:0]    acc_code;
    logic [1:0]    hits_sum;
    logic [3:0]    first_code;
    logic          res_valid;
    frame_t        res_kind;
    logic [3:0]    res_code;
    state_t        state;
    state_t        state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    cand;
    logic [3:0]    cand_d;
    logic [3:0]    key_code_d;
    logic          key_valid_d;
    logic          key_down_d;

    // Row dwell divider and row selector
    assign terminal  = (div == DW'(SCAN_DIV - 1));
    assign frame_end = terminal && (row_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= '0;
            row_idx <= '0;
        end else if (terminal) begin
            div     <= '0;
            row_idx <= row_idx + 2'd1;
        end else begin
            div     <= div + DW'(1);
        end
    end

    assign row_n = ~(4'b0001 << row_idx);

    // Two-flop column synchronizer; idles at "no key"
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta <= '1;
            col_s    <= '1;
        end else begin
            col_meta <= col_n;
            col_s    <= col_meta;
        end
    end

    // Classify the current row's columns
    always_comb begin
        act       = ~col_s;
        row_one   = 1'b1;
        row_multi = 1'b0;
        col_idx   = '0;
        case (act)
            4'b0000: row_one = 1'b0;
            4'b0001: col_idx = 2'd0;
            4'b0010: col_idx = 2'd1;
            4'b0100: col_idx = 2'd2;
            4'b1000: col_idx = 2'd3;
            default: begin
                row_one   = 1'b0;
                row_multi = 1'b1;
            end
        endcase
    end

    // A multi-column row saturates the hit count directly, so MULTI falls out
    // of "more than one hit" without a separate flag.
    always_comb begin
        hits_sum   = acc_hits;
        first_code = acc_code;
        if (row_multi) begin
            hits_sum = 2'd2;
        end else if (row_one) begin
            if (acc_hits == 2'd0) begin
                hits_sum   = 2'd1;
                first_code = {row_idx, col_idx};
            end else begin
                hits_sum   = 2'd2;
            end
        end
    end

    // Frame accumulator; the frame result is registered on the frame-end edge
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_hits  <= '0;
            acc_code  <= '0;
            res_valid <= 1'b0;
            res_kind  <= FR_NONE;
            res_code  <= '0;
        end else begin
            res_valid <= 1'b0;
            if (frame_end) begin
                acc_hits  <= '0;
                acc_code  <= '0;
                res_valid <= 1'b1;
                res_code  <= first_code;
                case (hits_sum)
                    2'd0:    res_kind <= FR_NONE;
                    2'd1:    res_kind <= FR_ONE;
                    default: res_kind <= FR_MULTI;
                endcase
            end else if (terminal) begin
                acc_hits <= hits_sum;
                acc_code <= first_code;
            end
        end
    end

    // Debounce FSM, advanced once per registered frame result
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            cand      <= cand_d;
            key_code  <= key_code_d;
            key_valid <= key_valid_d;
            key_down  <= key_down_d;
        end
    end

    assign cnt_inc = cnt + CW'(1);

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        cand_d      = cand;
        key_code_d  = key_code;
        key_down_d  = key_down;
        key_valid_d = 1'b0;
        if (res_valid) begin
            unique case (state)
                IDLE: begin
                    if (res_kind == FR_ONE) begin
                        state_d = DEB_PRESS;
                        cand_d  = res_code;
                        cnt_d   = CW'(1);
                    end
                end
                DEB_PRESS: begin
                    if (res_kind == FR_ONE) begin
                        if (res_code == cand) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == CW'(DEBOUNCE)) begin
                                state_d     = HELD;
                                key_code_d  = cand;
                                key_valid_d = 1'b1;
                                key_down_d  = 1'b1;
                            end
                        end else begin
                            cand_d = res_code;
                            cnt_d  = CW'(1);
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (res_kind == FR_NONE) begin
                        state_d = DEB_REL;
                        cnt_d   = CW'(1);
                    end
                end
                DEB_REL: begin
                    if (res_kind == FR_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE)) begin
                            state_d    = IDLE;
                            key_down_d = 1'b0;
                            cnt_d      = '0;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=3.
// A keypad matrix model drives col_n from row_n. Key changes happen at frame
// starts (cycle 16*f after reset release), so an accepted press from frame f
// pulses key_valid in cycle 16*f+49 and a release from frame f drops key_down
// in cycle 16*f+49. Expected pulses are queued and checked by a monitor.
module tb_keypad_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] keys = '0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [3:0] code;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    // Matrix model: column c pulled low when a pressed key in that column
    // sits on the currently driven row.
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic expect_pulse(input logic [3:0] code, input int at);
        exp_t e;
        e.code = code;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic goto_cyc(input int n);
        while (cyc != n) @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse at cyc %0d: got code %0d expected no pulse", cyc, key_code);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(mon_e.at));
                check("pulse_code", 32'(key_code), 32'(mon_e.code));
                check("pulse_key_down", 32'(key_down), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] one;
        logic [3:0] exp_row;
        one = 4'b0001;

        // Reset and scan
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_row_n", 32'(row_n), 32'(4'b1110));
        check("reset_key_code", 32'(key_code), 32'd0);
        check("reset_key_valid", 32'(key_valid), 32'd0);
        check("reset_key_down", 32'(key_down), 32'd0);
        rst = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            goto_cyc(k);
            exp_row = ~(one << ((k / 4) % 4));
            check("scan_row_n", 32'(row_n), 32'(exp_row));
        end

        // Single press of (2,1), held through frame 14
        goto_cyc(16);
        keys[9] = 1'b1;
        expect_pulse(4'd9, 65);
        goto_cyc(64);
        check("press_not_yet_down", 32'(key_down), 32'd0);
        goto_cyc(66);
        check("press_key_down", 32'(key_down), 32'd1);
        check("press_key_code", 32'(key_code), 32'd9);

        // Release, then press (0,3)
        goto_cyc(240);
        keys = '0;
        goto_cyc(288);
        check("release_still_down", 32'(key_down), 32'd1);
        keys[3] = 1'b1;
        expect_pulse(4'd3, 337);
        goto_cyc(289);
        check("release_key_down", 32'(key_down), 32'd0);
        check("release_no_valid", 32'(key_valid), 32'd0);
        goto_cyc(338);
        check("press2_key_code", 32'(key_code), 32'd3);
        check("press2_key_down", 32'(key_down), 32'd1);
        goto_cyc(352);
        keys = '0;
        goto_cyc(400);
        check("release2_still_down", 32'(key_down), 32'd1);
        goto_cyc(401);
        check("release2_key_down", 32'(key_down), 32'd0);

        // Bounce on (1,2): 2 frames on, 1 off, 2 on, off
        goto_cyc(416);
        keys[6] = 1'b1;
        goto_cyc(448);
        keys = '0;
        goto_cyc(464);
        keys[6] = 1'b1;
        goto_cyc(496);
        keys = '0;
        goto_cyc(498);
        check("bounce_key_down_a", 32'(key_down), 32'd0);
        goto_cyc(514);
        check("bounce_key_down_b", 32'(key_down), 32'd0);
        check("bounce_key_code", 32'(key_code), 32'd3);

        // Multi press (0,0)+(3,3)
        goto_cyc(528);
        keys[0]  = 1'b1;
        keys[15] = 1'b1;
        goto_cyc(592);
        keys = '0;
        goto_cyc(600);
        check("multi_key_down", 32'(key_down), 32'd0);
        check("multi_key_code", 32'(key_code), 32'd3);

        // Rollover: hold 9 until accepted, then add (0,3)
        goto_cyc(624);
        keys[9] = 1'b1;
        expect_pulse(4'd9, 673);
        goto_cyc(672);
        keys[3] = 1'b1;
        goto_cyc(736);
        check("rollover_key_code", 32'(key_code), 32'd9);
        check("rollover_key_down", 32'(key_down), 32'd1);
        keys = '0;
        goto_cyc(784);
        check("rollover_still_down", 32'(key_down), 32'd1);
        goto_cyc(785);
        check("rollover_release", 32'(key_down), 32'd0);

        // Reset after 2 matching frames of key 9
        goto_cyc(816);
        keys[9] = 1'b1;
        goto_cyc(850);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("midreset_row_n", 32'(row_n), 32'(4'b1110));
        check("midreset_key_code", 32'(key_code), 32'd0);
        check("midreset_key_down", 32'(key_down), 32'd0);
        check("midreset_key_valid", 32'(key_valid), 32'd0);
        rst = 1'b0;
        expect_pulse(4'd9, 49);
        goto_cyc(48);
        check("midreset_not_yet_down", 32'(key_down), 32'd0);
        goto_cyc(50);
        check("midreset_key_down", 32'(key_down), 32'd1);
        check("midreset_key_code_after", 32'(key_code), 32'd9);
        goto_cyc(64);
        keys = '0;
        goto_cyc(112);
        check("midreset_still_down", 32'(key_down), 32'd1);
        goto_cyc(113);
        check("midreset_release", 32'(key_down), 32'd0);

        goto_cyc(130);
        check("pulses_outstanding", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
